// File: rtl/chirp_nco_pkg.sv
// Shared types and default widths for the chirp NCO.
// Holds the sweep FSM state encoding and parameter defaults.
package chirp_nco_pkg;

    localparam int DEF_M        = 10;
    localparam int DEF_DAC_BITS = 12;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_LEN_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/chirp_nco_if.sv
// Bundle between chirp_nco and its environment.
// master = NCO side (sweep control in, ROM address and samples out);
// slave  = sweep controller / ROM / DAC side.
interface chirp_nco_if
    import chirp_nco_pkg::*;
#(
    parameter int M        = DEF_M,
    parameter int DAC_BITS = DEF_DAC_BITS,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int LEN_W    = DEF_LEN_W
) ();

    logic                start;
    logic [ACC_W-1:0]    f0;
    logic [ACC_W-1:0]    k;
    logic [LEN_W-1:0]    len;
    logic [M-1:0]        rom_addr;
    logic [DAC_BITS-1:0] rom_data;
    logic [DAC_BITS-1:0] sample;
    logic                sample_valid;
    logic                busy;
    logic                done;

    modport master (
        input  start, f0, k, len, rom_data,
        output rom_addr, sample, sample_valid, busy, done
    );

    modport slave (
        output start, f0, k, len, rom_data,
        input  rom_addr, sample, sample_valid, busy, done
    );

endinterface

// File: rtl/chirp_nco_phase_acc.sv
// chirp_phase_acc: second-order phase accumulator (phase, freq, rate).
// Ports: load (start: phase=f0, freq=f0+k), step (advance one sample),
// f0/k parameters, top = upper M bits of the current phase.
module chirp_phase_acc #(
    parameter int ACC_W = 32,
    parameter int M     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [ACC_W-1:0] f0,
    input  logic [ACC_W-1:0] k,
    output logic [M-1:0]     top
);

    logic [ACC_W-1:0] phase_q, phase_d;
    logic [ACC_W-1:0] freq_q, freq_d;
    logic [ACC_W-1:0] k_q, k_d;

    always_comb begin
        phase_d = phase_q;
        freq_d  = freq_q;
        k_d     = k_q;
        if (load) begin
            phase_d = f0;
            freq_d  = f0 + k;
            k_d     = k;
        end else if (step) begin
            phase_d = phase_q + freq_q;
            freq_d  = freq_q + k_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            freq_q  <= '0;
            k_q     <= '0;
        end else begin
            phase_q <= phase_d;
            freq_q  <= freq_d;
            k_q     <= k_d;
        end
    end

    assign top = phase_q[ACC_W-1 -: M];

endmodule

// File: rtl/chirp_nco.sv
// Chirp NCO: linear-FM phase sweep driving a sine ROM address port.
// Ports: clk, rst_n (async, active-low), bus (chirp_nco_if.master).
module chirp_nco
    import chirp_nco_pkg::*;
#(
    parameter int M        = DEF_M,
    parameter int DAC_BITS = DEF_DAC_BITS,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    chirp_nco_if.master  bus
);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [M-1:0]        rom_addr_q, rom_addr_d;
    logic [DAC_BITS-1:0] sample_q, sample_d;
    logic                issue_q, issue_d;
    logic                stage1_q, stage1_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                zero_q, zero_d;
    logic                load;
    logic                step;
    logic [M-1:0]        phase_top;

    chirp_phase_acc #(
        .ACC_W (ACC_W),
        .M     (M)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .f0    (bus.f0),
        .k     (bus.k),
        .top   (phase_top)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        rom_addr_d = rom_addr_q;
        busy_d     = busy_q;
        issue_d    = 1'b0;
        zero_d     = 1'b0;
        // zero-length start reports done one cycle late
        done_d     = zero_q;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        load       = 1'b1;
                        rom_addr_d = '0;
                        cnt_d      = LEN_W'(1);
                        len_d      = bus.len;
                        busy_d     = 1'b1;
                        issue_d    = 1'b1;
                        state_d    = ST_SWEEP;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                if (cnt_q < len_q) begin
                    step       = 1'b1;
                    rom_addr_d = phase_top;
                    cnt_d      = cnt_q + LEN_W'(1);
                    issue_d    = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // last read is in stage1; it lands on this edge
                if (!issue_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stage1_d = issue_q;
    assign valid_d  = stage1_q;
    assign sample_d = stage1_q ? bus.rom_data : sample_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            rom_addr_q <= '0;
            sample_q   <= '0;
            issue_q    <= 1'b0;
            stage1_q   <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            rom_addr_q <= rom_addr_d;
            sample_q   <= sample_d;
            issue_q    <= issue_d;
            stage1_q   <= stage1_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_chirp_nco.sv
// Scoreboard bench for chirp_nco with a registered ROM model.
// Driver pushes expected samples/lengths; monitor pops on valid/done.
module tb_chirp_nco;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chirp_nco_if bus ();

    chirp_nco dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [11:0] rom [1024];
    initial bus.rom_data = '0;
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int nvec = 0;
    int nerr = 0;
    logic [11:0] exp_q[$];
    int          len_q[$];
    int          sweep_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // phase of sample n = n*f0 + k*n(n-1)/2 mod 2^32; address = top 10 bits
    function automatic logic [9:0] ref_addr(input logic [31:0] f0v,
                                           input logic [31:0] kv,
                                           input int n);
        logic [63:0] p;
        p = 64'(n) * 64'(f0v) + 64'(kv) * 64'((n * (n - 1)) / 2);
        return p[31:22];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sweep_cnt = 0;
        end else begin
            if (bus.sample_valid) begin
                if (exp_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL spurious_valid act=%0h exp=none", bus.sample);
                end else begin
                    chk("sample", 64'(bus.sample), 64'(exp_q.pop_front()));
                end
                sweep_cnt++;
            end
            if (bus.done) begin
                if (len_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL spurious_done act=1 exp=0");
                end else begin
                    int l;
                    l = len_q.pop_front();
                    chk("sweep_len", 64'(sweep_cnt), 64'(l));
                    chk("done_busy", 64'(bus.busy), 64'(0));
                    if (l > 0)
                        chk("done_with_last_valid", 64'(bus.sample_valid), 64'(1));
                end
                sweep_cnt = 0;
            end
        end
    end

    task automatic run_sweep(input logic [31:0] f0v, input logic [31:0] kv,
                             input int n, input int mid);
        int c;
        bus.start = 1'b1;
        bus.f0    = f0v;
        bus.k     = kv;
        bus.len   = 16'(n);
        len_q.push_back(n);
        for (int i = 0; i < n; i++) exp_q.push_back(rom[ref_addr(f0v, kv, i)]);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.f0    = $urandom;
        bus.k     = $urandom;
        bus.len   = 16'($urandom);
        if (n == 0) begin
            chk("zl_done_early", 64'(bus.done), 64'(0));
            @(posedge clk); #1;
            chk("zl_done", 64'(bus.done), 64'(1));
            chk("zl_busy", 64'(bus.busy), 64'(0));
            return;
        end
        for (int i = 0; i < n; i++) begin
            chk("rom_addr", 64'(bus.rom_addr), 64'(ref_addr(f0v, kv, i)));
            chk("busy", 64'(bus.busy), 64'(1));
            if (i == mid) begin
                bus.start = 1'b1;
                bus.f0    = $urandom;
                bus.len   = 16'($urandom_range(1, 30));
            end else begin
                bus.start = 1'b0;
            end
            if (i < n - 1) begin
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_latency", 64'(c), 64'(2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 12'($urandom);
        bus.start = 1'b0;
        bus.f0    = '0;
        bus.k     = '0;
        bus.len   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {bus.rom_addr, bus.sample, bus.sample_valid, bus.busy, bus.done},
            64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep(32'h0040_0000, 32'h0, 4, -1);
        run_sweep(32'h0, 32'h0040_0000, 5, -1);
        run_sweep(32'h8000_0000, 32'h0, 3, -1);
        run_sweep(32'h0, 32'h0, 0, -1);
        run_sweep($urandom, $urandom, 10, 4);
        run_sweep(32'h0123_4567, 32'hFFF0_0000, 1, -1);

        bus.start = 1'b1;
        bus.f0    = $urandom;
        bus.k     = $urandom;
        bus.len   = 16'd8;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        exp_q.delete();
        len_q.delete();
        #1;
        chk("async_reset_outputs",
            {bus.rom_addr, bus.sample, bus.sample_valid, bus.busy, bus.done},
            64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("reset_no_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle", {bus.busy, bus.done, bus.sample_valid}, 64'(0));
        run_sweep($urandom, $urandom, 8, -1);

        for (int t = 0; t < 12; t++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            run_sweep($urandom, $urandom, n,
                      (n > 3) ? int'($urandom_range(0, n - 2)) : -1);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
        chk("len_q_empty", 64'(len_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
